// File: rtl/bcd_cascade_counter.sv
// Cascaded BCD up/down counter with a clock prescaler.
// State changes on the falling clock edge. Reset is asynchronous.
module bcd_cascade_counter #(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   out,
  output logic                  carry
);

  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX =
    PW'(PRESCALE - 1);

  logic [PW-1:0]         pre_q, pre_d;
  logic [4*DIGITS-1:0]   cnt_q, cnt_d;
  logic                  carry_q, carry_d;
  logic                  chain;
  logic [3:0]            dig, nd;

  always_comb begin
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    carry_d = 1'b0;
    chain   = 1'b1;
    dig     = '0;
    nd      = '0;
    if (load) begin
      pre_d = '0;
      // Any digit above 9 is stored as 0.
      for (int i = 0; i < DIGITS; i++) begin
        dig = load_val[4*i +: 4];
        cnt_d[4*i +: 4] = (dig > 4'd9) ? 4'd0 : dig;
      end
    end else if (en) begin
      if (pre_q == PRE_MAX) begin
        pre_d = '0;
        // chain stays set while every lower digit wrapped.
        for (int i = 0; i < DIGITS; i++) begin
          dig = cnt_q[4*i +: 4];
          nd  = dig;
          if (chain) begin
            if (up_down) begin
              if (dig == 4'd9) begin
                nd = 4'd0;
              end else begin
                nd    = dig + 4'd1;
                chain = 1'b0;
              end
            end else begin
              if (dig == 4'd0) begin
                nd = 4'd9;
              end else begin
                nd    = dig - 4'd1;
                chain = 1'b0;
              end
            end
          end
          cnt_d[4*i +: 4] = nd;
        end
        carry_d = chain;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      pre_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

  assign out   = cnt_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Randomized and directed bench for bcd_cascade_counter
// against an integer-valued reference model.
module tb_bcd_cascade_counter;

  localparam int D  = 2;
  localparam int PS = 5;
  localparam int MAXV = 99;

  logic           clk = 1'b1;
  logic           reset = 1'b1;
  logic           en = 1'b0;
  logic           up_down = 1'b1;
  logic           load = 1'b0;
  logic [4*D-1:0] load_val = '0;
  logic [4*D-1:0] out;
  logic           carry;

  int errors = 0;
  int checks = 0;

  int m_val = 0;
  int m_pre = 0;
  bit m_carry = 0;

  always #5 clk = ~clk;

  bcd_cascade_counter #(.DIGITS(D), .PRESCALE(PS)) dut (
    .clk(clk), .reset(reset), .en(en),
    .up_down(up_down), .load(load),
    .load_val(load_val), .out(out), .carry(carry)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int from_load(input logic [4*D-1:0] lv);
    int v, w, n;
    v = 0;
    w = 1;
    for (int i = 0; i < D; i++) begin
      n = int'(lv[4*i +: 4]);
      if (n > 9) n = 0;
      v += n * w;
      w *= 10;
    end
    return v;
  endfunction

  task automatic model_edge();
    m_carry = 0;
    if (load) begin
      m_val = from_load(load_val);
      m_pre = 0;
    end else if (en) begin
      if (m_pre == PS - 1) begin
        m_pre = 0;
        if (up_down) begin
          if (m_val == MAXV) begin
            m_val = 0;
            m_carry = 1;
          end else m_val++;
        end else begin
          if (m_val == 0) begin
            m_val = MAXV;
            m_carry = 1;
          end else m_val--;
        end
      end else m_pre++;
    end
  endtask

  task automatic edge_chk(input string tag);
    @(negedge clk);
    model_edge();
    #1;
    check({tag, "_out"}, 32'(out), 32'(to_bcd(m_val)));
    check({tag, "_cy"}, 32'(carry), 32'(m_carry));
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    #1;
    m_val = 0;
    m_pre = 0;
    m_carry = 0;
    check("arst_out", 32'(out), 32'h0);
    check("arst_cy", 32'(carry), 32'h0);
    reset = 1'b0;
  endtask

  task automatic do_load(input logic [4*D-1:0] v);
    load = 1'b1;
    load_val = v;
    edge_chk("load");
    load = 1'b0;
  endtask

  int cy_cnt;

  initial begin
    #2;
    check("rst_out", 32'(out), 32'h0);
    check("rst_cy", 32'(carry), 32'h0);
    @(negedge clk);
    #1 reset = 1'b0;

    // Count up 00..10 over 50 edges, carry stays low.
    en = 1'b1;
    up_down = 1'b1;
    for (int i = 1; i <= 50; i++) edge_chk("up50");
    check("up50_end", 32'(out), 32'h10);

    // Up-wrap from 98.
    do_load(8'h98);
    check("ld98", 32'(out), 32'h98);
    cy_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      edge_chk("wrapup");
      if (i == 5) check("wrapup_99", 32'(out), 32'h99);
      if (carry) cy_cnt++;
    end
    check("wrapup_00", 32'(out), 32'h00);
    edge_chk("wrapup_after");
    check("wrapup_cyoff", 32'(carry), 32'h0);
    check("wrapup_pulses", 32'(cy_cnt), 32'd1);

    // Down-wrap from 00.
    do_load(8'h00);
    up_down = 1'b0;
    for (int i = 1; i <= 5; i++) edge_chk("wrapdn");
    check("wrapdn_99", 32'(out), 32'h99);
    check("wrapdn_cy", 32'(carry), 32'h1);
    for (int i = 1; i <= 5; i++) edge_chk("dn98");
    check("dn98", 32'(out), 32'h98);

    // Sanitised loads, including with en low.
    en = 1'b0;
    do_load(8'hA7);
    check("ldA7", 32'(out), 32'h07);
    do_load(8'h3F);
    check("ld3F", 32'(out), 32'h30);
    do_load(8'hFF);
    check("ldFF", 32'(out), 32'h00);

    // Enable gap: step on the 2nd edge after re-enable.
    en = 1'b1;
    up_down = 1'b1;
    do_load(8'h20);
    for (int i = 0; i < 3; i++) edge_chk("gap_a");
    en = 1'b0;
    for (int i = 0; i < 10; i++) edge_chk("gap_hold");
    check("gap_hold_v", 32'(out), 32'h20);
    en = 1'b1;
    edge_chk("gap_r1");
    check("gap_r1_v", 32'(out), 32'h20);
    edge_chk("gap_r2");
    check("gap_r2_v", 32'(out), 32'h21);

    // Async reset at 45 with prescaler 3.
    do_load(8'h45);
    for (int i = 0; i < 3; i++) edge_chk("pre3");
    pulse_reset();
    for (int i = 1; i <= 4; i++) edge_chk("post_rst");
    check("post_rst4", 32'(out), 32'h00);
    edge_chk("post_rst5");
    check("post_rst5_v", 32'(out), 32'h01);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0)
        up_down = ~up_down;
      load = ($urandom_range(0, 29) == 0);
      load_val = 8'($urandom);
      edge_chk("rnd");
      load = 1'b0;
      if ($urandom_range(0, 199) == 0) pulse_reset();
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_cascade_counter.md
BCD_CASCADE_COUNTER -- requirements
Module: bcd_cascade_counter

Interface
REQ-001 Parameter DIGITS, default 2: number of cascaded BCD digits, legal range 1..8.
REQ-002 Parameter PRESCALE, default 5: clock edges per count step, legal range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on the falling edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  count enable; when low, the prescaler and count hold.
REQ-006 up_down  input  1  direction select: 1 = increment, 0 = decrement.
REQ-007 load  input  1  synchronous load strobe.
REQ-008 load_val  input  4*DIGITS  BCD load value; digit 0 occupies bits [3:0].
REQ-009 out  output  4*DIGITS  registered BCD count; digit 0 occupies bits [3:0].
REQ-010 carry  output  1  registered one-cycle pulse on wrap-around in either direction.

Function
REQ-011 The design SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-012 Prescaler: internal counter of width ceil(log2(PRESCALE)) (minimum 1 bit), range 0..PRESCALE-1.
REQ-013 Step event: en=1 AND prescaler=PRESCALE-1 at a falling edge; PRESCALE=1 gives a step on every enabled edge.
REQ-014 With en=1 and no step event, the prescaler SHALL increment by 1 per falling edge; on a step event it SHALL return to 0.
REQ-015 With en=0, the prescaler, out and the internal state SHALL hold, and carry SHALL be 0.
REQ-016 Up step: digit 0 SHALL increment; a digit at 9 SHALL go to 0 and propagate a borrow-free carry into the next digit in the same edge.
REQ-017 Down step: digit 0 SHALL decrement; a digit at 0 SHALL go to 9 and propagate a borrow into the next digit in the same edge.
REQ-018 Wrap: up from all-9s SHALL go to all-0s; down from all-0s SHALL go to all-9s; carry SHALL be 1 for exactly the following cycle.
REQ-019 carry SHALL be 0 on every edge without a wrap.
REQ-020 Load priority: load=1 SHALL override counting regardless of en.
REQ-021 On a load edge: out <= load_val, prescaler <= 0, carry <= 0.
REQ-022 Load digit sanitising: any load_val digit greater than 9 SHALL be stored as 0; the other digits SHALL load unchanged.
REQ-023 up_down SHALL be sampled only on step edges; a change between steps SHALL have no other effect.
REQ-024 out SHALL always hold valid BCD (each digit 0..9).
REQ-025 Latency: out SHALL change on the same falling edge as the step or load event, with no combinational path from inputs to outputs.

Reset
REQ-026 While reset=1: out=0, carry=0, prescaler=0, asynchronously and independent of clk.
REQ-027 Reset asserted mid-prescale or mid-load SHALL discard all pending progress.
REQ-028 After reset deasserts, the first step SHALL occur on the PRESCALE-th enabled falling edge.

Verification (DIGITS=2, PRESCALE=5)
REQ-029 Reset release, en=1, up_down=1, 50 falling edges -> out steps 00,01,...,10; each step lands on edges 5,10,...,50; carry stays 0.
REQ-030 load_val=8'h98 loaded, up, 10 enabled edges -> out=99 after edge 5, then 00 after edge 10; carry=1 for exactly one cycle after edge 10.
REQ-031 out=00, up_down=0, 5 enabled edges -> out=99, one-cycle carry pulse; 5 more edges -> out=98.
REQ-032 load_val=8'hA7 -> out=07; load_val=8'h3F -> out=30; load with en=0 still loads.
REQ-033 en dropped after 3 edges for 10 edges, then raised -> the step occurs on the 2nd edge after re-enable.
REQ-034 reset pulsed asynchronously between edges at out=45 with prescaler=3 -> out=00 immediately; the next step occurs 5 enabled edges after release.
